// File: rtl/ressource_grid_pkg.sv
// Shared definitions for the resource-grid publisher/subscriber pair:
// frame numbering limits, field widths, tuser packing and FSM states.
package ressource_grid_pkg;

    localparam int SFN_WIDTH             = 10;
    localparam int SUBFRAME_NUMBER_WIDTH = 5;
    localparam int SYMBOL_NUMBER_WIDTH   = 4;
    localparam int USER_WIDTH            = SFN_WIDTH + SUBFRAME_NUMBER_WIDTH + SYMBOL_NUMBER_WIDTH + 1;

    localparam int SFN_MAX               = (1 << SFN_WIDTH) - 1;
    localparam int SUBFRAMES_PER_FRAME   = 20;
    localparam int SYM_PER_SF            = 14;

    // tuser layout, MSB first: {sfn, subframe, symbol, zero_flag}
    typedef struct packed {
        logic [SFN_WIDTH-1:0]             sfn;
        logic [SUBFRAME_NUMBER_WIDTH-1:0] subframe;
        logic [SYMBOL_NUMBER_WIDTH-1:0]   symbol;
        logic                             zero_flag;
    } tuser_t;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STREAM = 2'd1,
        ST_ZERO   = 2'd2
    } state_t;

endpackage

// File: rtl/ressource_grid_publisher_frame_counter.sv
// Symbol/subframe/sfn cascade. Advances once per completed segment and
// exposes a copy latched at segment start so tuser stays constant.
module frame_counter
    import ressource_grid_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             advance,
    input  logic                             latch,
    output logic [SFN_WIDTH-1:0]             sfn,
    output logic [SUBFRAME_NUMBER_WIDTH-1:0] subframe,
    output logic [SYMBOL_NUMBER_WIDTH-1:0]   symbol
);

    localparam logic [SYMBOL_NUMBER_WIDTH-1:0]   SYM_LAST = SYMBOL_NUMBER_WIDTH'(SYM_PER_SF - 1);
    localparam logic [SUBFRAME_NUMBER_WIDTH-1:0] SF_LAST  = SUBFRAME_NUMBER_WIDTH'(SUBFRAMES_PER_FRAME - 1);
    localparam logic [SFN_WIDTH-1:0]             SFN_LAST = SFN_WIDTH'(SFN_MAX);

    logic [SFN_WIDTH-1:0]             sfn_q;
    logic [SUBFRAME_NUMBER_WIDTH-1:0] subframe_q;
    logic [SYMBOL_NUMBER_WIDTH-1:0]   symbol_q;

    // Running counters: symbol carries into subframe, subframe into sfn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfn_q      <= '0;
            subframe_q <= '0;
            symbol_q   <= '0;
        end else if (advance) begin
            if (symbol_q == SYM_LAST) begin
                symbol_q <= '0;
                if (subframe_q == SF_LAST) begin
                    subframe_q <= '0;
                    sfn_q      <= (sfn_q == SFN_LAST) ? '0 : sfn_q + SFN_WIDTH'(1);
                end else begin
                    subframe_q <= subframe_q + SUBFRAME_NUMBER_WIDTH'(1);
                end
            end else begin
                symbol_q <= symbol_q + SYMBOL_NUMBER_WIDTH'(1);
            end
        end
    end

    // Snapshot of the running counters taken when a segment starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfn      <= '0;
            subframe <= '0;
            symbol   <= '0;
        end else if (latch) begin
            sfn      <= sfn_q;
            subframe <= subframe_q;
            symbol   <= symbol_q;
        end
    end

endmodule

// File: rtl/ressource_grid_publisher.sv
// Replays resource-grid samples from the ring-reader FIFO as symbol-framed
// IQ segments, released on the symbol strobe. Substitutes an all-zero
// segment when the FIFO is empty at strobe time so symbol timing holds.
module ressource_grid_publisher
    import ressource_grid_pkg::*;
#(
    parameter int NUM_SEGMENTS = 10,
    parameter int SEGMENT_SIZE = 240,
    parameter int IQ_WIDTH     = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            enable_i,
    input  logic                            sym_strobe_i,
    input  logic [IQ_WIDTH-1:0]             s_axis_fifo_tdata,
    input  logic                            s_axis_fifo_tvalid,
    output logic                            s_axis_fifo_tready,
    output logic [IQ_WIDTH-1:0]             m_axis_iq_tdata,
    output logic                            m_axis_iq_tvalid,
    input  logic                            m_axis_iq_tready,
    output logic [USER_WIDTH-1:0]           m_axis_iq_tuser,
    output logic                            m_axis_iq_tlast,
    output logic [$clog2(NUM_SEGMENTS)-1:0] last_segment_o,
    output logic                            underflow_o,
    output logic                            overrun_o,
    output logic                            int_o
);

    localparam int CNT_W = $clog2(SEGMENT_SIZE + 1);
    localparam int IDX_W = $clog2(NUM_SEGMENTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SEGMENT_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SEGMENT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGMENTS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [IDX_W-1:0]   ring_idx_q;
    logic               zero_flag_q;

    logic               out_free, out_hs, seg_done;
    logic               start, load, underflow_d, overrun_d;

    logic [SFN_WIDTH-1:0]             fc_sfn;
    logic [SUBFRAME_NUMBER_WIDTH-1:0] fc_subframe;
    logic [SYMBOL_NUMBER_WIDTH-1:0]   fc_symbol;
    tuser_t                           tuser;

    assign out_free = !m_axis_iq_tvalid || m_axis_iq_tready;
    assign out_hs   = m_axis_iq_tvalid && m_axis_iq_tready;
    assign seg_done = out_hs && m_axis_iq_tlast;

    assign m_axis_iq_tlast = m_axis_iq_tvalid && (out_cnt_q == LAST_CNT);

    assign tuser = '{sfn: fc_sfn, subframe: fc_subframe, symbol: fc_symbol, zero_flag: zero_flag_q};
    assign m_axis_iq_tuser = tuser;

    frame_counter u_frame_counter (
        .clk      (clk_i),
        .rst_n    (reset_ni),
        .advance  (seg_done),
        .latch    (start),
        .sfn      (fc_sfn),
        .subframe (fc_subframe),
        .symbol   (fc_symbol)
    );

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, FIFO pull and output-register load decisions.
    // in_cnt stops the pull after a full segment while the last sample
    // still waits in the output register for its handshake.
    always_comb begin
        state_d            = state_q;
        start              = 1'b0;
        load               = 1'b0;
        underflow_d        = 1'b0;
        overrun_d          = 1'b0;
        s_axis_fifo_tready = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (sym_strobe_i && enable_i) begin
                    start = 1'b1;
                    if (s_axis_fifo_tvalid) begin
                        state_d = ST_STREAM;
                    end else begin
                        state_d     = ST_ZERO;
                        underflow_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                overrun_d          = sym_strobe_i && enable_i;
                s_axis_fifo_tready = out_free && (in_cnt_q != FULL_CNT);
                load               = s_axis_fifo_tready && s_axis_fifo_tvalid;
                if (seg_done) begin
                    state_d = ST_WAIT;
                end
            end
            ST_ZERO: begin
                overrun_d = sym_strobe_i && enable_i;
                load      = out_free && (in_cnt_q != FULL_CNT);
                if (seg_done) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Output register, sample counters, ring index and status pulses
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            m_axis_iq_tdata  <= '0;
            m_axis_iq_tvalid <= 1'b0;
            in_cnt_q         <= '0;
            out_cnt_q        <= '0;
            ring_idx_q       <= '0;
            zero_flag_q      <= 1'b0;
            last_segment_o   <= LAST_IDX;
            underflow_o      <= 1'b0;
            overrun_o        <= 1'b0;
            int_o            <= 1'b0;
        end else begin
            underflow_o <= underflow_d;
            overrun_o   <= overrun_d;
            int_o       <= 1'b0;

            if (start) begin
                zero_flag_q <= !s_axis_fifo_tvalid;
            end

            if (load) begin
                m_axis_iq_tdata  <= (state_q == ST_STREAM) ? s_axis_fifo_tdata : '0;
                m_axis_iq_tvalid <= 1'b1;
                in_cnt_q         <= in_cnt_q + CNT_W'(1);
            end else if (out_hs) begin
                m_axis_iq_tvalid <= 1'b0;
            end

            if (out_hs) begin
                out_cnt_q <= seg_done ? '0 : out_cnt_q + CNT_W'(1);
            end

            if (seg_done) begin
                in_cnt_q <= '0;
                if (state_q == ST_STREAM) begin
                    last_segment_o <= ring_idx_q;
                    ring_idx_q     <= (ring_idx_q == LAST_IDX) ? '0 : ring_idx_q + IDX_W'(1);
                    int_o          <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ressource_grid_publisher.sv
// Directed bench for ressource_grid_publisher: streaming, underflow,
// backpressure, overrun, ring index wrap, frame counter wrap, reset.
`define CHECK(TAG, OBS, EXP) \
    begin \
        n_checks++; \
        assert ((OBS) === (EXP)) else begin \
            n_errors++; \
            $error("FAIL %s: observed 0x%0h expected 0x%0h", TAG, OBS, EXP); \
        end \
    end

module tb_ressource_grid_publisher;
    import ressource_grid_pkg::*;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        enable;
    logic        strobe;
    logic [15:0] fifo_tdata;
    logic        fifo_tvalid;
    logic        fifo_tready;
    logic [15:0] iq_tdata;
    logic        iq_tvalid;
    logic        iq_tready;
    logic [19:0] iq_tuser;
    logic        iq_tlast;
    logic [3:0]  last_segment;
    logic        underflow;
    logic        overrun;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ressource_grid_publisher #(
        .NUM_SEGMENTS (10),
        .SEGMENT_SIZE (240),
        .IQ_WIDTH     (16)
    ) dut (
        .clk_i              (clk),
        .reset_ni           (reset_ni),
        .enable_i           (enable),
        .sym_strobe_i       (strobe),
        .s_axis_fifo_tdata  (fifo_tdata),
        .s_axis_fifo_tvalid (fifo_tvalid),
        .s_axis_fifo_tready (fifo_tready),
        .m_axis_iq_tdata    (iq_tdata),
        .m_axis_iq_tvalid   (iq_tvalid),
        .m_axis_iq_tready   (iq_tready),
        .m_axis_iq_tuser    (iq_tuser),
        .m_axis_iq_tlast    (iq_tlast),
        .last_segment_o     (last_segment),
        .underflow_o        (underflow),
        .overrun_o          (overrun),
        .int_o              (irq)
    );

    // Source FIFO model
    logic [15:0] fifo_mem [0:4095];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_tvalid = (rd_ptr != wr_ptr);
    assign fifo_tdata  = fifo_mem[rd_ptr[11:0]];

    always @(posedge clk) begin
        if (fifo_tready && fifo_tvalid) rd_ptr <= rd_ptr + 1;
    end

    // Output monitor, sampled on the falling edge
    logic [15:0] cap_data [0:4095];
    logic        cap_last [0:4095];
    logic [19:0] seg_user [0:1023];
    int          seg_len  [0:1023];
    logic [3:0]  int_seg  [0:63];
    int cap_n = 0, seg_cnt = 0, run_len = 0, int_cnt = 0;
    int uf_cnt = 0, ov_cnt = 0, tl_cnt = 0, stall_cnt = 0, viol_cnt = 0;
    logic        held = 1'b0;
    logic [15:0] h_data;
    logic [19:0] h_user;
    logic        h_last;

    always @(negedge clk) begin
        if (!reset_ni) begin
            run_len <= 0;
            held    <= 1'b0;
        end else begin
            if (iq_tvalid && iq_tready) begin
                cap_data[cap_n[11:0]] <= iq_tdata;
                cap_last[cap_n[11:0]] <= iq_tlast;
                cap_n <= cap_n + 1;
                if (iq_tlast) begin
                    seg_user[seg_cnt[9:0]] <= iq_tuser;
                    seg_len[seg_cnt[9:0]]  <= run_len + 1;
                    seg_cnt <= seg_cnt + 1;
                    tl_cnt  <= tl_cnt + 1;
                    run_len <= 0;
                end else begin
                    run_len <= run_len + 1;
                end
            end
            if (irq) begin
                int_seg[int_cnt[5:0]] <= last_segment;
                int_cnt <= int_cnt + 1;
            end
            if (underflow) uf_cnt <= uf_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
            if (held && !(iq_tvalid && iq_tdata === h_data && iq_tuser === h_user && iq_tlast === h_last))
                viol_cnt <= viol_cnt + 1;
            if (iq_tvalid && !iq_tready) stall_cnt <= stall_cnt + 1;
            held   <= iq_tvalid && !iq_tready;
            h_data <= iq_tdata;
            h_user <= iq_tuser;
            h_last <= iq_tlast;
        end
    end

    task automatic push(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[11:0]] = 16'(base + i);
            wr_ptr++;
        end
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        wr_ptr   = rd_ptr;
        @(posedge clk); #1;
        reset_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic strobe_pulse();
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic wait_segs(input int target, input int budget);
        int i = 0;
        while (seg_cnt < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk); #1;
        `CHECK("seg_timeout", seg_cnt >= target, 1'b1)
    endtask

    initial begin
        int b_cap, b_seg, b_int, b_uf, b_ov, b_tl, b_st, b_vi, mism;

        reset_ni  = 1'b0;
        enable    = 1'b1;
        strobe    = 1'b0;
        iq_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        `CHECK("rst_tvalid", iq_tvalid, 1'b0)
        `CHECK("rst_tlast", iq_tlast, 1'b0)
        `CHECK("rst_tdata", iq_tdata, 16'h0)
        `CHECK("rst_tuser", iq_tuser, 20'h0)
        `CHECK("rst_fifo_tready", fifo_tready, 1'b0)
        `CHECK("rst_last_segment", last_segment, 4'd9)
        `CHECK("rst_pulses", {underflow, overrun, irq}, 3'b000)
        reset_ni = 1'b1;
        @(posedge clk); #1;

        // Two streamed segments, strobes 300 cycles apart
        do_reset();
        push(0, 480);
        b_cap = cap_n; b_seg = seg_cnt; b_int = int_cnt; b_uf = uf_cnt; b_tl = tl_cnt;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        `CHECK("t1_tvalid_after_1", iq_tvalid, 1'b0)
        @(posedge clk); #1;
        `CHECK("t1_tvalid_after_2", iq_tvalid, 1'b1)
        `CHECK("t1_first_data", iq_tdata, 16'd0)
        repeat (298) @(posedge clk);
        #1;
        strobe_pulse();
        wait_segs(b_seg + 2, 400);
        `CHECK("t1_sample_count", cap_n - b_cap, 480)
        mism = 0;
        for (int i = 0; i < 480; i++) if (cap_data[12'(b_cap + i)] !== 16'(i)) mism++;
        `CHECK("t1_data", mism, 0)
        `CHECK("t1_len0", seg_len[b_seg], 240)
        `CHECK("t1_len1", seg_len[b_seg + 1], 240)
        `CHECK("t1_user0", seg_user[b_seg], 20'h0)
        `CHECK("t1_user1", seg_user[b_seg + 1], 20'h2)
        `CHECK("t1_tlast_239", cap_last[12'(b_cap + 239)], 1'b1)
        `CHECK("t1_tlast_479", cap_last[12'(b_cap + 479)], 1'b1)
        `CHECK("t1_tlast_count", tl_cnt - b_tl, 2)
        `CHECK("t1_int_count", int_cnt - b_int, 2)
        `CHECK("t1_int_seg0", int_seg[6'(b_int)], 4'd0)
        `CHECK("t1_int_seg1", int_seg[6'(b_int + 1)], 4'd1)
        `CHECK("t1_underflow", uf_cnt - b_uf, 0)

        // Underflow: empty FIFO produces a zero segment
        do_reset();
        b_cap = cap_n; b_seg = seg_cnt; b_int = int_cnt; b_uf = uf_cnt;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        `CHECK("t2_underflow_hi", underflow, 1'b1)
        `CHECK("t2_fifo_tready", fifo_tready, 1'b0)
        @(posedge clk); #1;
        `CHECK("t2_underflow_lo", underflow, 1'b0)
        wait_segs(b_seg + 1, 300);
        `CHECK("t2_uf_count", uf_cnt - b_uf, 1)
        `CHECK("t2_len", seg_len[b_seg], 240)
        `CHECK("t2_user", seg_user[b_seg], 20'h1)
        mism = 0;
        for (int i = 0; i < 240; i++) if (cap_data[12'(b_cap + i)] !== 16'h0) mism++;
        `CHECK("t2_zero_data", mism, 0)
        `CHECK("t2_int_count", int_cnt - b_int, 0)
        `CHECK("t2_last_segment", last_segment, 4'd9)

        // Downstream backpressure at 50%
        do_reset();
        push(16'hA000, 240);
        b_cap = cap_n; b_seg = seg_cnt; b_st = stall_cnt; b_vi = viol_cnt;
        strobe_pulse();
        for (int i = 0; i < 1000 && seg_cnt < b_seg + 1; i++) begin
            iq_tready = ~iq_tready;
            @(posedge clk); #1;
        end
        iq_tready = 1'b1;
        wait_segs(b_seg + 1, 10);
        `CHECK("t3_sample_count", cap_n - b_cap, 240)
        mism = 0;
        for (int i = 0; i < 240; i++) if (cap_data[12'(b_cap + i)] !== 16'(16'hA000 + i)) mism++;
        `CHECK("t3_data", mism, 0)
        `CHECK("t3_stalls_seen", (stall_cnt - b_st) > 0, 1'b1)
        `CHECK("t3_stall_stable", viol_cnt - b_vi, 0)

        // Overrun: second strobe 100 cycles into the segment
        do_reset();
        push(16'h3000, 240);
        b_cap = cap_n; b_seg = seg_cnt; b_ov = ov_cnt;
        strobe_pulse();
        repeat (100) @(posedge clk);
        #1;
        strobe_pulse();
        wait_segs(b_seg + 1, 400);
        `CHECK("t4_overrun", ov_cnt - b_ov, 1)
        `CHECK("t4_len", seg_len[b_seg], 240)
        `CHECK("t4_sample_count", cap_n - b_cap, 240)
        strobe_pulse();
        wait_segs(b_seg + 2, 300);
        `CHECK("t4_next_user", seg_user[b_seg + 1], 20'h3)

        // Ring index wrap over 11 consumed segments
        do_reset();
        push(16'h1000, 2640);
        b_seg = seg_cnt; b_int = int_cnt;
        for (int k = 0; k < 11; k++) begin
            strobe_pulse();
            wait_segs(b_seg + k + 1, 300);
        end
        `CHECK("t5_int_count", int_cnt - b_int, 11)
        mism = 0;
        for (int k = 0; k < 11; k++) if (int_seg[6'(b_int + k)] !== 4'(k % 10)) mism++;
        `CHECK("t5_seg_sequence", mism, 0)
        `CHECK("t5_last_segment", last_segment, 4'd0)

        // Frame counter wrap with zero segments
        do_reset();
        b_seg = seg_cnt; b_int = int_cnt;
        for (int k = 0; k < 281; k++) begin
            strobe_pulse();
            wait_segs(b_seg + k + 1, 300);
        end
        `CHECK("t6_user13", seg_user[b_seg + 13], 20'h0001B)
        `CHECK("t6_user14", seg_user[b_seg + 14], 20'h00021)
        `CHECK("t6_user279", seg_user[b_seg + 279], 20'h0027B)
        `CHECK("t6_user280", seg_user[b_seg + 280], 20'h00401)
        `CHECK("t6_int_count", int_cnt - b_int, 0)

        // Reset in the middle of a streamed segment
        do_reset();
        b_seg = seg_cnt;
        strobe_pulse();
        wait_segs(b_seg + 1, 300);
        push(16'h5000, 240);
        b_cap = cap_n;
        strobe_pulse();
        for (int i = 0; i < 400 && (cap_n - b_cap) < 120; i++) begin
            @(posedge clk); #1;
        end
        `CHECK("t7_reached_120", (cap_n - b_cap) >= 120, 1'b1)
        reset_ni = 1'b0;
        #1;
        `CHECK("t7_tvalid", iq_tvalid, 1'b0)
        `CHECK("t7_tlast", iq_tlast, 1'b0)
        `CHECK("t7_tdata", iq_tdata, 16'h0)
        `CHECK("t7_tuser", iq_tuser, 20'h0)
        `CHECK("t7_fifo_tready", fifo_tready, 1'b0)
        `CHECK("t7_last_segment", last_segment, 4'd9)
        `CHECK("t7_pulses", {underflow, overrun, irq}, 3'b000)
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        reset_ni = 1'b1;
        @(posedge clk); #1;
        b_seg = seg_cnt;
        strobe_pulse();
        wait_segs(b_seg + 1, 300);
        `CHECK("t7_restart_user", seg_user[b_seg], 20'h1)

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
